sys_cmd_master: RTL and testbench
=================================

# sys_cmd_master

Command-frame initiator for the REF_CLK domain: it is the host end of the register/ALU byte protocol that the system controller decodes. It accepts one parallel command, serialises it into protocol bytes (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands) toward the UART TX path, then collects the response bytes from the RX path and returns a single result word. Used as an on-chip master and as the loopback driver in system-level benches.

## Interface
- BUS_WIDTH, 8, protocol byte width
- Reg_Addr, 4, register address width, zero-extended into the address byte
- ALU_FUN, 4, ALU function width, zero-extended into the function byte
- TIMEOUT, 4096, response wait limit in REF_CLK cycles (>=2)
- REF_CLK in 1 system clock, rising edge
- SYNC_RST in 1 reset, asynchronous, active-low
- CMD_VALID in 1 command request
- CMD_READY out 1 high only in IDLE
- CMD_TYPE in 2 0=write(AA), 1=read(BB), 2=ALU w/ operands(CC), 3=ALU no operands(DD)
- CMD_ADDR in Reg_Addr register address
- CMD_DATA in BUS_WIDTH write data
- CMD_OP_A, CMD_OP_B in BUS_WIDTH ALU operands
- CMD_FUN in ALU_FUN ALU function
- TX_DATA out BUS_WIDTH byte to transmitter
- TX_VALID out 1 byte present
- TX_READY in 1 transmitter accepts byte
- RX_DATA in BUS_WIDTH+1 response byte; bit BUS_WIDTH is a one-cycle valid flag
- RSP_DATA out 2*BUS_WIDTH result word
- RSP_VALID out 1 one-cycle completion pulse
- RSP_TIMEOUT out 1 one-cycle timeout pulse
- BUSY out 1 high in any state other than IDLE

## Operation
- States: IDLE, SEND, WAIT_RSP.
- IDLE: CMD_VALID && CMD_READY captures all CMD_* fields into registers, builds frame, loads byte index 0 -> SEND.
- Frames: write = AA, addr, data (3 bytes); read = BB, addr (2); CC = CC, A, B, fun (4); DD = DD, fun (2).
- SEND: TX_VALID=1, TX_DATA=frame[index]. Byte transfers when TX_VALID && TX_READY; index increments. TX_DATA stable while TX_READY low.
- Last byte accepted: write -> RSP_VALID pulse, RSP_DATA=0, -> IDLE (no response expected). Read -> WAIT_RSP expecting 1 byte; CC/DD -> WAIT_RSP expecting 2 bytes.
- WAIT_RSP: each RX_DATA[BUS_WIDTH]=1 consumes one byte. Read: RSP_DATA={0, byte}. ALU: first byte -> RSP_DATA[7:0], second -> RSP_DATA[15:8] (LSB first). Final byte -> RSP_VALID pulse, -> IDLE.
- Timeout counter clears on WAIT_RSP entry and on every consumed byte; reaching TIMEOUT-1 with no byte -> RSP_TIMEOUT pulse, RSP_DATA keeps partial value, -> IDLE.
- RX bytes outside WAIT_RSP are ignored (no state change), except a byte arriving in the same cycle as the last TX byte acceptance, which is counted as the first response byte.
- CMD_VALID while BUSY is ignored; no queueing.

## Timing
- Reset (async, SYNC_RST low): state IDLE, CMD_READY=1, TX_VALID=0, TX_DATA=0, RSP_DATA=0, RSP_VALID=0, RSP_TIMEOUT=0, BUSY=0, counters 0.
- All outputs registered except CMD_READY and BUSY (decoded from state register).
- Command accept at edge N -> TX_VALID=1 with opcode from N+1.
- Minimum frame time with TX_READY tied high: write 3 cycles to RSP_VALID; read 2 cycles + response.
- RSP_VALID/RSP_TIMEOUT asserted the cycle after the completing event, for exactly one cycle; CMD_READY high same cycle.
- RSP_VALID and RSP_TIMEOUT never assert together.
- Reset mid-frame aborts immediately; no partial byte re-sent afterwards.

## Structure
- Shared package: opcode constants (AA/BB/CC/DD), CMD_TYPE encodings, state encoding, expected-response-length constants.
- One sub-module: cmd_rsp_timer (clear, enable, parameterised TIMEOUT terminal-count pulse).

## Test plan
- Write type 0, addr 5, data 0x3C, TX_READY=1 -> TX bytes AA,05,3C on consecutive cycles; RSP_VALID with RSP_DATA=0x0000.
- Read addr 2, RX byte 0x7E after 10 cycles -> TX BB,02; RSP_DATA=0x007E, RSP_VALID one cycle.
- CC A=0x12 B=0x34 fun=1, TX_READY toggling 1/0 -> bytes CC,12,34,01 each held until accepted; RX 0x46 then 0x00 -> RSP_DATA=0x0046.
- DD fun=3, one RX byte only -> RSP_TIMEOUT exactly TIMEOUT cycles later, no RSP_VALID, RSP_DATA[7:0]=byte.
- Stray RX bytes in IDLE, CMD_VALID while BUSY -> ignored; next read completes normally.
- SYNC_RST low during SEND byte 2 -> all outputs to reset values immediately; new command starts from opcode byte.

Source files
------------

// File: rtl/sys_cmd_master_pkg.sv
// -----------------------------------------------------------------------------
// sys_cmd_master_pkg
// Shared definitions for the command-frame initiator: protocol opcodes,
// command type encodings, FSM state encoding and per-command frame and
// response lengths.
// -----------------------------------------------------------------------------
package sys_cmd_master_pkg;

   // Protocol opcode bytes sent as the first byte of every frame
   localparam logic [7:0] OpWrite   = 8'hAA;
   localparam logic [7:0] OpRead    = 8'hBB;
   localparam logic [7:0] OpAluOp   = 8'hCC;
   localparam logic [7:0] OpAluNoOp = 8'hDD;

   // Encoding of the CMD_TYPE input
   typedef enum logic [1:0] {
      CmdWrite   = 2'd0,
      CmdRead    = 2'd1,
      CmdAluOp   = 2'd2,
      CmdAluNoOp = 2'd3
   } cmd_type_e;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSend    = 2'd1,
      StWaitRsp = 2'd2
   } state_e;

   // Index of the last byte of each frame (frame length minus one)
   localparam logic [1:0] LastIdxWrite   = 2'd2;
   localparam logic [1:0] LastIdxRead    = 2'd1;
   localparam logic [1:0] LastIdxAluOp   = 2'd3;
   localparam logic [1:0] LastIdxAluNoOp = 2'd1;

   // Number of response bytes expected after the frame has been sent
   localparam logic [1:0] RspLenNone = 2'd0;
   localparam logic [1:0] RspLenRead = 2'd1;
   localparam logic [1:0] RspLenAlu  = 2'd2;

   function automatic logic [1:0] frame_last_idx(input cmd_type_e cmd_type);
      logic [1:0] last_idx;
      last_idx = LastIdxWrite;
      unique case (cmd_type)
         CmdWrite:   last_idx = LastIdxWrite;
         CmdRead:    last_idx = LastIdxRead;
         CmdAluOp:   last_idx = LastIdxAluOp;
         CmdAluNoOp: last_idx = LastIdxAluNoOp;
         default:    last_idx = LastIdxWrite;
      endcase
      return last_idx;
   endfunction

   function automatic logic [1:0] rsp_len(input cmd_type_e cmd_type);
      logic [1:0] len;
      len = RspLenNone;
      unique case (cmd_type)
         CmdWrite:   len = RspLenNone;
         CmdRead:    len = RspLenRead;
         CmdAluOp:   len = RspLenAlu;
         CmdAluNoOp: len = RspLenAlu;
         default:    len = RspLenNone;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/sys_cmd_master_cmd_rsp_timer.sv
// -----------------------------------------------------------------------------
// sys_cmd_master_cmd_rsp_timer (cmd_rsp_timer)
// Response-wait timer. Counts REF_CLK cycles while enabled; a clear or a
// disabled cycle returns the count to zero. o_expired is high in the cycle
// in which the count has reached TIMEOUT-1 without a clear.
//
// Ports:
//   REF_CLK    - system clock, rising edge
//   SYNC_RST   - asynchronous active-low reset
//   i_clear    - restart the count (response byte consumed)
//   i_enable   - count while high (waiting for a response)
//   o_expired  - terminal-count indication
// -----------------------------------------------------------------------------
module sys_cmd_master_cmd_rsp_timer #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic REF_CLK,
   input  logic SYNC_RST,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] r_cnt;

   always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
      if (!SYNC_RST) begin
         r_cnt <= '0;
      end else if (i_clear || !i_enable) begin
         r_cnt <= '0;
      end else if (r_cnt != TermCnt) begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

   assign o_expired = i_enable && !i_clear && (r_cnt == TermCnt);

endmodule

// File: rtl/sys_cmd_master.sv
// -----------------------------------------------------------------------------
// sys_cmd_master
// Host end of the register/ALU byte protocol. Captures one parallel command,
// serialises it as a frame of protocol bytes toward the UART TX path, then
// collects the response bytes from the RX path and returns one result word.
//
// Ports:
//   REF_CLK, SYNC_RST      - clock (rising edge), async active-low reset
//   i_cmd_valid/o_cmd_ready- command handshake (ready only when idle)
//   i_cmd_type             - 0 write, 1 read, 2 ALU w/ operands, 3 ALU no operands
//   i_cmd_addr/data/op_a/op_b/fun - command fields
//   o_tx_data/o_tx_valid/i_tx_ready - byte stream to transmitter
//   i_rx_data              - response byte, MSB is a one-cycle valid flag
//   o_rsp_data             - result word (first response byte in the low half)
//   o_rsp_valid            - one-cycle completion pulse
//   o_rsp_timeout          - one-cycle timeout pulse
//   o_busy                 - high whenever not idle
// -----------------------------------------------------------------------------
module sys_cmd_master
   import sys_cmd_master_pkg::*;
#(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned Reg_Addr  = 4,
   parameter int unsigned ALU_FUN   = 4,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic                   REF_CLK,
   input  logic                   SYNC_RST,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [1:0]             i_cmd_type,
   input  logic [Reg_Addr-1:0]    i_cmd_addr,
   input  logic [BUS_WIDTH-1:0]   i_cmd_data,
   input  logic [BUS_WIDTH-1:0]   i_cmd_op_a,
   input  logic [BUS_WIDTH-1:0]   i_cmd_op_b,
   input  logic [ALU_FUN-1:0]     i_cmd_fun,
   output logic [BUS_WIDTH-1:0]   o_tx_data,
   output logic                   o_tx_valid,
   input  logic                   i_tx_ready,
   input  logic [BUS_WIDTH:0]     i_rx_data,
   output logic [2*BUS_WIDTH-1:0] o_rsp_data,
   output logic                   o_rsp_valid,
   output logic                   o_rsp_timeout,
   output logic                   o_busy
);

   state_e                      r_state;
   cmd_type_e                   r_type;
   logic [3:0][BUS_WIDTH-1:0]   r_frame;
   logic [1:0]                  r_idx;
   logic [1:0]                  r_rx_cnt;
   logic [BUS_WIDTH-1:0]        r_tx_data;
   logic                        r_tx_valid;
   logic [2*BUS_WIDTH-1:0]      r_rsp_data;
   logic                        r_rsp_valid;
   logic                        r_rsp_timeout;

   cmd_type_e                   w_cmd_type;
   logic [3:0][BUS_WIDTH-1:0]   w_frame;
   logic                        w_rx_vld;
   logic [BUS_WIDTH-1:0]        w_rx_byte;
   logic                        w_tmr_expired;
   logic                        w_last_byte;

   assign w_cmd_type  = cmd_type_e'(i_cmd_type);
   assign w_rx_vld    = i_rx_data[BUS_WIDTH];
   assign w_rx_byte   = i_rx_data[BUS_WIDTH-1:0];
   assign w_last_byte = (r_idx == frame_last_idx(r_type));

   // Frame image built from the live command inputs; registered on accept
   always_comb begin
      w_frame = '0;
      unique case (w_cmd_type)
         CmdWrite: begin
            w_frame[0] = BUS_WIDTH'(OpWrite);
            w_frame[1] = BUS_WIDTH'(i_cmd_addr);
            w_frame[2] = i_cmd_data;
         end
         CmdRead: begin
            w_frame[0] = BUS_WIDTH'(OpRead);
            w_frame[1] = BUS_WIDTH'(i_cmd_addr);
         end
         CmdAluOp: begin
            w_frame[0] = BUS_WIDTH'(OpAluOp);
            w_frame[1] = i_cmd_op_a;
            w_frame[2] = i_cmd_op_b;
            w_frame[3] = BUS_WIDTH'(i_cmd_fun);
         end
         CmdAluNoOp: begin
            w_frame[0] = BUS_WIDTH'(OpAluNoOp);
            w_frame[1] = BUS_WIDTH'(i_cmd_fun);
         end
         default: w_frame = '0;
      endcase
   end

   // Timer runs only while waiting; it is held at zero in every other state,
   // so entry into StWaitRsp always starts from a cleared count.
   sys_cmd_master_cmd_rsp_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_cmd_rsp_timer (
      .REF_CLK   (REF_CLK),
      .SYNC_RST  (SYNC_RST),
      .i_clear   (w_rx_vld),
      .i_enable  (r_state == StWaitRsp),
      .o_expired (w_tmr_expired)
   );

   always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
      if (!SYNC_RST) begin
         r_state       <= StIdle;
         r_type        <= CmdWrite;
         r_frame       <= '0;
         r_idx         <= '0;
         r_rx_cnt      <= '0;
         r_tx_data     <= '0;
         r_tx_valid    <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_cmd_valid) begin
                  r_type     <= w_cmd_type;
                  r_frame    <= w_frame;
                  r_idx      <= '0;
                  r_rx_cnt   <= '0;
                  r_tx_data  <= w_frame[0];
                  r_tx_valid <= 1'b1;
                  r_rsp_data <= '0;
                  r_state    <= StSend;
               end
            end
            StSend: begin
               // TX_VALID is always high here, so TX_READY alone completes a transfer
               if (i_tx_ready) begin
                  if (w_last_byte) begin
                     r_tx_valid <= 1'b0;
                     r_tx_data  <= '0;
                     if (r_type == CmdWrite) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_state     <= StIdle;
                     end else if (w_rx_vld) begin
                        // Response byte coincident with the last TX byte is the first one
                        r_rsp_data[BUS_WIDTH-1:0] <= w_rx_byte;
                        if (rsp_len(r_type) == RspLenRead) begin
                           r_rsp_valid <= 1'b1;
                           r_state     <= StIdle;
                        end else begin
                           r_rx_cnt <= 2'd1;
                           r_state  <= StWaitRsp;
                        end
                     end else begin
                        r_state <= StWaitRsp;
                     end
                  end else begin
                     r_idx     <= r_idx + 2'd1;
                     r_tx_data <= r_frame[r_idx + 2'd1];
                  end
               end
            end
            StWaitRsp: begin
               if (w_rx_vld) begin
                  if (r_rx_cnt == 2'd0) begin
                     r_rsp_data[BUS_WIDTH-1:0] <= w_rx_byte;
                  end else begin
                     r_rsp_data[2*BUS_WIDTH-1:BUS_WIDTH] <= w_rx_byte;
                  end
                  if ((r_rx_cnt + 2'd1) == rsp_len(r_type)) begin
                     r_rsp_valid <= 1'b1;
                     r_state     <= StIdle;
                  end else begin
                     r_rx_cnt <= r_rx_cnt + 2'd1;
                  end
               end else if (w_tmr_expired) begin
                  // Partial response stays visible on RSP_DATA
                  r_rsp_timeout <= 1'b1;
                  r_state       <= StIdle;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_tx_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_cmd_ready   = (r_state == StIdle);
   assign o_busy        = (r_state != StIdle);
   assign o_tx_data     = r_tx_data;
   assign o_tx_valid    = r_tx_valid;
   assign o_rsp_data    = r_rsp_data;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_sys_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_sys_cmd_master
// Directed bench for sys_cmd_master. Expected TX bytes and responses are
// queued when commands are issued and compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_sys_cmd_master;

   localparam int unsigned TO = 32;

   typedef struct {
      bit          timeout;
      logic [15:0] data;
      int          dly_acc;  // negedges from command accept, -1 = not checked
      int          dly_rx;   // negedges from last RX byte, -1 = not checked
   } rsp_t;

   logic        REF_CLK   = 1'b0;
   logic        SYNC_RST  = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_type  = 2'd0;
   logic [3:0]  cmd_addr  = 4'd0;
   logic [7:0]  cmd_data  = 8'd0;
   logic [7:0]  op_a      = 8'd0;
   logic [7:0]  op_b      = 8'd0;
   logic [3:0]  cmd_fun   = 4'd0;
   logic        tx_ready  = 1'b0;
   logic [8:0]  rx_data   = 9'd0;

   logic        cmd_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic [15:0] rsp_data;
   logic        rsp_valid;
   logic        rsp_timeout;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   int rx_cyc   = 0;

   logic [7:0] tx_q [$];
   rsp_t       rsp_q [$];

   sys_cmd_master #(
      .BUS_WIDTH (8),
      .Reg_Addr  (4),
      .ALU_FUN   (4),
      .TIMEOUT   (TO)
   ) u_dut (
      .REF_CLK       (REF_CLK),
      .SYNC_RST      (SYNC_RST),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_type    (cmd_type),
      .i_cmd_addr    (cmd_addr),
      .i_cmd_data    (cmd_data),
      .i_cmd_op_a    (op_a),
      .i_cmd_op_b    (op_b),
      .i_cmd_fun     (cmd_fun),
      .o_tx_data     (tx_data),
      .o_tx_valid    (tx_valid),
      .i_tx_ready    (tx_ready),
      .i_rx_data     (rx_data),
      .o_rsp_data    (rsp_data),
      .o_rsp_valid   (rsp_valid),
      .o_rsp_timeout (rsp_timeout),
      .o_busy        (busy)
   );

   always #5 REF_CLK = ~REF_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge REF_CLK);
         #1;
      end
   endtask

   task automatic push_rsp(input bit to, input logic [15:0] d, input int da, input int dr);
      rsp_t e;
      e.timeout = to;
      e.data    = d;
      e.dly_acc = da;
      e.dly_rx  = dr;
      rsp_q.push_back(e);
   endtask

   // Scoreboard side: samples on the falling edge, away from DUT updates
   task automatic monitor();
      rsp_t e;
      forever begin
         @(negedge REF_CLK);
         cyc++;
         if (SYNC_RST) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (rx_data[8]) rx_cyc = cyc;
            if (tx_valid) begin
               if (tx_q.size() == 0) chk("tx_unexpected", tx_valid, 0);
               else if (tx_ready) chk("tx_byte", tx_data, tx_q.pop_front());
               else chk("tx_hold", tx_data, tx_q[0]);
            end
            if (rsp_valid || rsp_timeout) begin
               if (rsp_q.size() == 0) begin
                  chk("rsp_unexpected", rsp_valid | rsp_timeout, 0);
               end else begin
                  e = rsp_q.pop_front();
                  chk("rsp_valid", rsp_valid, !e.timeout);
                  chk("rsp_timeout", rsp_timeout, e.timeout);
                  chk("rsp_data", rsp_data, e.data);
                  chk("rsp_cmd_ready", cmd_ready, 1);
                  if (e.dly_acc >= 0) chk("rsp_latency_accept", cyc - acc_cyc, e.dly_acc);
                  if (e.dly_rx >= 0) chk("rsp_latency_rx", cyc - rx_cyc, e.dly_rx);
               end
            end
         end
      end
   endtask

   task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                           input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] f);
      int         n = 0;
      logic [7:0] op;
      while (!cmd_ready && n < 200) begin
         idle(1);
         n++;
      end
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_type = t;
      cmd_addr = a;
      cmd_data = d;
      op_a     = opa;
      op_b     = opb;
      cmd_fun  = f;
      case (t)
         2'd0: begin
            op = 8'hAA;
            tx_q.push_back(8'hAA); tx_q.push_back({4'h0, a}); tx_q.push_back(d);
         end
         2'd1: begin
            op = 8'hBB;
            tx_q.push_back(8'hBB); tx_q.push_back({4'h0, a});
         end
         2'd2: begin
            op = 8'hCC;
            tx_q.push_back(8'hCC); tx_q.push_back(opa); tx_q.push_back(opb);
            tx_q.push_back({4'h0, f});
         end
         default: begin
            op = 8'hDD;
            tx_q.push_back(8'hDD); tx_q.push_back({4'h0, f});
         end
      endcase
      cmd_valid = 1'b1;
      idle(1);
      cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("ready_after_accept", cmd_ready, 0);
      chk("tx_valid_after_accept", tx_valid, 1);
      chk("tx_opcode_after_accept", tx_data, op);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data = {1'b1, b};
      idle(1);
      rx_data = 9'd0;
   endtask

   task automatic wait_tx_empty(input int max);
      int n = 0;
      while (tx_q.size() != 0 && n < max) begin
         idle(1);
         n++;
      end
      chk("tx_q_drained", tx_q.size(), 0);
   endtask

   task automatic wait_rsp(input int max);
      int n = 0;
      while (rsp_q.size() != 0 && n < max) begin
         idle(1);
         n++;
      end
      chk("rsp_q_drained", rsp_q.size(), 0);
   endtask

   // The completion pulse must be gone on the following cycle
   task automatic pulse_done();
      @(negedge REF_CLK);
      chk("rsp_valid_one_cycle", rsp_valid, 0);
      chk("rsp_timeout_one_cycle", rsp_timeout, 0);
      idle(1);
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset values
      #2 SYNC_RST = 1'b0;
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      idle(3);
      SYNC_RST = 1'b1;
      idle(2);

      // Write: AA,05,3C back to back, RSP_VALID 3 edges after accept
      tx_ready = 1'b1;
      push_rsp(1'b0, 16'h0000, 4, -1);
      send_cmd(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0);
      wait_rsp(20);
      pulse_done();

      // Read with a late response byte
      push_rsp(1'b0, 16'h007E, -1, -1);
      send_cmd(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0);
      idle(10);
      rx_byte(8'h7E);
      wait_rsp(40);
      pulse_done();

      // ALU with operands, transmitter alternately stalling
      push_rsp(1'b0, 16'h0046, -1, -1);
      fork
         begin
            repeat (20) begin
               idle(1);
               tx_ready = ~tx_ready;
            end
            tx_ready = 1'b1;
         end
         begin
            send_cmd(2'd2, 4'd0, 8'h00, 8'h12, 8'h34, 4'd1);
            wait_tx_empty(60);
            rx_byte(8'h46);
            rx_byte(8'h00);
            wait_rsp(40);
            pulse_done();
         end
      join

      // ALU without operands, only one response byte: timeout
      tx_ready = 1'b1;
      push_rsp(1'b1, 16'h00A5, -1, TO + 1);
      send_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd3);
      wait_tx_empty(20);
      idle(3);
      rx_byte(8'hA5);
      wait_rsp(TO + 20);
      pulse_done();

      // Stray RX byte while idle
      rx_byte(8'h55);
      idle(2);
      chk("stray_rx_busy", busy, 0);
      chk("stray_rx_ready", cmd_ready, 1);

      // Command held valid while busy must be ignored
      push_rsp(1'b0, 16'h0011, -1, -1);
      send_cmd(2'd1, 4'd9, 8'h00, 8'h00, 8'h00, 4'd0);
      cmd_type  = 2'd0;
      cmd_addr  = 4'hF;
      cmd_data  = 8'hEE;
      cmd_valid = 1'b1;
      idle(3);
      cmd_valid = 1'b0;
      wait_tx_empty(20);
      rx_byte(8'h11);
      wait_rsp(40);
      pulse_done();

      // Read whose response arrives with the last TX byte
      push_rsp(1'b0, 16'h00C3, 3, -1);
      send_cmd(2'd1, 4'd3, 8'h00, 8'h00, 8'h00, 4'd0);
      idle(1);
      rx_byte(8'hC3);
      wait_rsp(20);
      pulse_done();

      // Reset while the third write byte is stalled
      send_cmd(2'd0, 4'd7, 8'h99, 8'h00, 8'h00, 4'd0);
      idle(2);
      tx_ready = 1'b0;
      @(negedge REF_CLK);
      #2 SYNC_RST = 1'b0;
      #1;
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_tx_data", tx_data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_rsp_data", rsp_data, 0);
      tx_q.delete();
      idle(1);
      SYNC_RST = 1'b1;
      tx_ready = 1'b1;
      idle(1);
      push_rsp(1'b0, 16'h0000, 4, -1);
      send_cmd(2'd0, 4'd1, 8'h22, 8'h00, 8'h00, 4'd0);
      wait_rsp(20);
      pulse_done();

      idle(2);
      chk("final_tx_q_empty", tx_q.size(), 0);
      chk("final_rsp_q_empty", rsp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
